// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op encodings, FSM state type and op-decode helpers for mdu_iter.
// Contents: MDU_* funct3 encodings, state_t (IDLE/PREP/CALC/FIX/DONE), is_div/is_signed_a/is_signed_b.
package mdu_pkg;
    localparam logic [2:0] MDU_MUL    = 3'b000;
    localparam logic [2:0] MDU_MULH   = 3'b001;
    localparam logic [2:0] MDU_MULHSU = 3'b010;
    localparam logic [2:0] MDU_MULHU  = 3'b011;
    localparam logic [2:0] MDU_DIV    = 3'b100;
    localparam logic [2:0] MDU_DIVU   = 3'b101;
    localparam logic [2:0] MDU_REM    = 3'b110;
    localparam logic [2:0] MDU_REMU   = 3'b111;

    typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;

    function automatic logic is_div(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic is_signed_a(input logic [2:0] op);
        return op == MDU_MULH || op == MDU_MULHSU || op == MDU_DIV || op == MDU_REM;
    endfunction

    function automatic logic is_signed_b(input logic [2:0] op);
        return op == MDU_MULH || op == MDU_DIV || op == MDU_REM;
    endfunction
endpackage

// File: rtl/mdu_step.sv
// mdu_step: one combinational iteration of the unsigned multiply/divide datapath.
// Ports: div_i selects divide, acc_i current {hi:lo} accumulator, m_i multiplicand/divisor, acc_o next accumulator.
module mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic               div_i,
    input  logic [2*WIDTH:0]   acc_i,
    input  logic [WIDTH-1:0]   m_i,
    output logic [2*WIDTH:0]   acc_o
);
    logic [WIDTH:0]   sum;
    logic [WIDTH+1:0] diff;

    always_comb begin
        // multiply: add multiplicand into the high half when the multiplier LSB is set, then shift right
        sum  = acc_i[2*WIDTH:WIDTH] + (acc_i[0] ? {1'b0, m_i} : '0);
        // divide: trial-subtract divisor from the left-shifted remainder; the MSB of diff is the borrow
        diff = {1'b0, acc_i[2*WIDTH-1:WIDTH-1]} - {2'b0, m_i};
        acc_o = div_i ? (diff[WIDTH+1] ? {acc_i[2*WIDTH-1:0], 1'b0}
                                       : {diff[WIDTH:0], acc_i[WIDTH-2:0], 1'b1})
                      : {1'b0, sum, acc_i[WIDTH-1:1]};
    end
endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: iterative RV32M multiply/divide unit, one bit per cycle, with a fast path for div-by-zero and overflow.
// Ports: clk, rst_n (async, active low); in_valid/in_ready/op/a/b request; kill abort;
//        out_valid/out_ready/result/zero response; busy = not idle.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             kill,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_t             state_q, state_d;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   a_q, b_q, m_q, res_q;
    logic [2*WIDTH:0]   acc_q, acc_nxt;
    logic [CNT_W-1:0]   cnt_q;
    logic               neg_q, rneg_q;

    logic               accept, fast, sa, sb;
    logic [WIDTH-1:0]   abs_a, abs_b, fast_res, q_s, r_s, fix_res;
    logic [2*WIDTH-1:0] prod_s;

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .div_i (is_div(op_q)),
        .acc_i (acc_q),
        .m_i   (m_q),
        .acc_o (acc_nxt)
    );

    always_comb begin
        accept   = in_valid && in_ready;
        // only the divide corner cases skip iteration; both come straight from the request operands
        fast     = is_div(op) && (b == '0 || (is_signed_b(op) && a == {1'b1, {(WIDTH-1){1'b0}}} && b == '1));
        fast_res = b == '0 ? (op[1] ? a : '1) : (op[1] ? '0 : a);
        sa       = is_signed_a(op_q) && a_q[WIDTH-1];
        sb       = is_signed_b(op_q) && b_q[WIDTH-1];
        abs_a    = sa ? -a_q : a_q;
        abs_b    = sb ? -b_q : b_q;
        prod_s   = neg_q ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];
        q_s      = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        r_s      = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        fix_res  = is_div(op_q) ? (op_q[1] ? r_s : q_s)
                                : (op_q[1:0] == 2'b00 ? prod_s[WIDTH-1:0] : prod_s[2*WIDTH-1:WIDTH]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = accept ? (fast ? DONE : PREP) : IDLE;
            PREP:    state_d = CALC;
            CALC:    state_d = cnt_q == CNT_W'(1) ? FIX : CALC;
            FIX:     state_d = DONE;
            DONE:    state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
        // a flush beats everything except a fresh accept from IDLE
        if (kill && state_q != IDLE) state_d = IDLE;
    end

    always_comb begin
        in_ready  = state_q == IDLE;
        out_valid = state_q == DONE;
        busy      = state_q != IDLE;
        result    = res_q;
        zero      = res_q == '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            m_q    <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            neg_q  <= 1'b0;
            rneg_q <= 1'b0;
            res_q  <= '0;
        end else begin
            if (accept) begin
                op_q <= op;
                a_q  <= a;
                b_q  <= b;
                if (fast) res_q <= fast_res;
            end
            if (state_q == PREP) begin
                acc_q  <= {{(WIDTH+1){1'b0}}, abs_a};
                m_q    <= abs_b;
                neg_q  <= sa ^ sb;
                rneg_q <= sa;
                cnt_q  <= CNT_W'(WIDTH);
            end
            if (state_q == CALC) begin
                acc_q <= acc_nxt;
                cnt_q <= cnt_q - 1'b1;
            end
            if (state_q == FIX && !kill) res_q <= fix_res;
        end
    end
endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: directed self-checking bench for mdu_iter (WIDTH=32) with hand-computed expectations.
module tb_mdu_iter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = 3'b000;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        kill = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic        zero;
    logic        busy;

    int total = 0;
    int bad = 0;
    int lat;
    int seen;

    mdu_iter #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .kill      (kill),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // drive one request for a single edge; lat = edges after the accept edge until out_valid is seen
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        op = o;
        a = x;
        b = y;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    task automatic run(input string tag, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] exp, input int exp_lat);
        issue(o, x, y);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_res"}, result, exp);
        check({tag, "_zero"}, zero, exp == 0);
        tick();
        check({tag, "_idle"}, in_ready, 1);
    endtask

    initial begin
        #2;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_zero", zero, 1);
        check("rst_busy", busy, 0);
        #10 rst_n = 1'b1;
        tick();

        run("mul", 3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 34);
        run("mulh", 3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 34);
        run("mulhu", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34);
        run("mulhsu", 3'b010, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 34);
        run("div", 3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34);
        run("rem", 3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34);
        run("divu", 3'b101, 32'd100, 32'd7, 32'd14, 34);
        run("remu", 3'b111, 32'd100, 32'd7, 32'd2, 34);

        // fast path: result present in the cycle right after accept
        run("divu_by0", 3'b101, 32'd5, 32'd0, 32'hFFFFFFFF, 0);
        run("rem_by0", 3'b110, 32'd5, 32'd0, 32'd5, 0);
        run("div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0);
        run("rem_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0, 0);

        // kill in IDLE is ignored and the same-cycle accept still goes through
        kill = 1'b1;
        op = 3'b101;
        a = 32'd100;
        b = 32'd7;
        in_valid = 1'b1;
        tick();
        kill = 1'b0;
        in_valid = 1'b0;
        check("kill_idle_busy", busy, 1);
        lat = 0;
        while (!out_valid && lat < 200) begin
            tick();
            lat++;
        end
        check("kill_idle_res", result, 32'd14);
        tick();

        // back-pressure: DONE held, an in_valid meanwhile is not queued
        out_ready = 1'b0;
        issue(3'b000, 32'd3, 32'd5);
        check("bp_lat", lat, 34);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_res", result, 32'd15);
            check("bp_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_release_ready", in_ready, 1);
        check("bp_release_valid", out_valid, 0);
        tick();
        check("bp_not_queued", busy, 0);

        // kill mid-divide
        op = 3'b100;
        a = 32'd1000;
        b = 32'd3;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        kill = 1'b1;
        tick();
        kill = 1'b0;
        check("kill_busy", busy, 0);
        check("kill_in_ready", in_ready, 1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) seen++;
            tick();
        end
        check("kill_no_valid", seen, 0);

        // asynchronous reset mid-multiply
        op = 3'b000;
        a = 32'd9;
        b = 32'd9;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        #2 rst_n = 1'b0;
        #1;
        check("arst_in_ready", in_ready, 1);
        check("arst_out_valid", out_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_result", result, 0);
        check("arst_zero", zero, 1);
        #3 rst_n = 1'b1;
        tick();
        run("mul_after_rst", 3'b000, 32'd3, 32'd4, 32'd12, 34);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
